// File: rtl/spi_master.sv
// ----------------------------------------------------------------------------
// spi_master
//
// Parametrised SPI master for the SoC peripheral bus. It shifts one WIDTH-bit
// word per request, MSB first, in any of the four CPOL/CPHA modes. It drives
// one of NCS active-low chip selects and can keep that select asserted across
// words. The CPU side uses the ex (start) / wa (busy) / rv (valid) / ack
// handshake.
//
// Parameters
//   WIDTH  bits per word (>= 2)
//   NCS    number of chip selects (>= 2)
//   DIVW   width of i_clkdiv
//
// Ports
//   i_clk      sole clock, rising edge only
//   i_rst      asynchronous active-high reset
//   i_clkdiv   sclk half-period H = i_clkdiv + 1 clk cycles
//   i_cpol     sclk idle level
//   i_cpha     0: sample on leading edge, 1: sample on trailing edge
//   i_cs_sel   index of the chip select to drive
//   i_hold     keep the chip select asserted after this word
//   i_so       word to transmit
//   i_ex       start request (level or pulse), taken only while idle
//   i_ack      clears o_rv
//   o_si       received word, all ones while o_rv = 0
//   o_rv       received word valid
//   o_wa       busy
//   o_sclk     SPI clock
//   o_mosi     SPI data out (idles high)
//   i_miso     SPI data in
//   o_cs_n     active-low chip selects
//
// Every output comes straight from a flop.
// ----------------------------------------------------------------------------
module spi_master #(
    parameter int WIDTH = 8,
    parameter int NCS   = 2,
    parameter int DIVW  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [DIVW-1:0]        i_clkdiv,
    input  logic                   i_cpol,
    input  logic                   i_cpha,
    input  logic [$clog2(NCS)-1:0] i_cs_sel,
    input  logic                   i_hold,
    input  logic [WIDTH-1:0]       i_so,
    input  logic                   i_ex,
    input  logic                   i_ack,
    output logic [WIDTH-1:0]       o_si,
    output logic                   o_rv,
    output logic                   o_wa,
    output logic                   o_sclk,
    output logic                   o_mosi,
    input  logic                   i_miso,
    output logic [NCS-1:0]         o_cs_n
);

    localparam int CSW = $clog2(NCS);
    // The edge counter has to hold values up to 2*WIDTH.
    localparam int ECW = $clog2(2 * WIDTH + 1);
    localparam logic [ECW-1:0] LAST_EDGE  = ECW'(2 * WIDTH);
    localparam logic [ECW-1:0] LAST_SHIFT = ECW'(2 * WIDTH - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_END   = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Values latched when a request is accepted.
    logic [DIVW-1:0]  r_clkdiv;
    logic             r_cpol;
    logic             r_cpha;
    logic [CSW-1:0]   r_cs_sel;
    logic             r_hold;

    // Half-period down-counter and the count of sclk edges already produced.
    logic [DIVW-1:0]  r_div;
    logic [ECW-1:0]   r_edge_cnt;

    // Transmit and receive shift registers.
    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;

    // Set while a chip select stays low in IDLE after a word sent with hold = 1.
    logic             r_cs_held;

    // Output flops.
    logic             r_sclk;
    logic             r_mosi;
    logic [NCS-1:0]   r_cs_n;
    logic             r_wa;
    logic             r_rv;
    logic [WIDTH-1:0] r_si;

    // Decoded strobes.
    logic             w_tick;
    logic             w_accept;
    logic             w_need_gap;
    logic             w_gap_done;
    logic             w_done;
    logic             w_edge_fire;
    logic [ECW-1:0]   w_edge_num;
    logic             w_leading;
    logic             w_sample;
    logic             w_shift;

    // Builds the chip-select pattern that drives only line idx low.
    function automatic logic [NCS-1:0] cs_pattern(input logic [CSW-1:0] idx);
        logic [NCS-1:0] m;
        for (int i = 0; i < NCS; i++) begin
            m[i] = (CSW'(i) != idx);
        end
        return m;
    endfunction

    // Decodes half-period boundaries and classifies the sclk edge due on them.
    always_comb begin
        w_tick      = (r_div == {DIVW{1'b0}});
        w_accept    = (r_state == S_IDLE) && i_ex;
        // The select we are holding belongs to another slave, so it has to be
        // released for a full half-period before the new one drops.
        w_need_gap  = r_cs_held && (r_cs_sel != i_cs_sel);
        w_gap_done  = (r_state == S_GAP) && w_tick;
        w_done      = (r_state == S_END) && w_tick;
        w_edge_num  = r_edge_cnt + ECW'(1);
        // Odd-numbered edges are leading edges, even-numbered ones trailing.
        w_leading   = w_edge_num[0];
        if (w_tick && ((r_state == S_SETUP) ||
                       ((r_state == S_XFER) && (r_edge_cnt != LAST_EDGE)))) begin
            w_edge_fire = 1'b1;
        end else begin
            w_edge_fire = 1'b0;
        end
        w_sample    = w_edge_fire && (w_leading != r_cpha);
        if (r_cpha) begin
            // The MSB is already on mosi, so the first leading edge does not shift.
            w_shift = w_edge_fire && w_leading && (w_edge_num != ECW'(1));
        end else begin
            w_shift = w_edge_fire && !w_leading && (w_edge_num <= LAST_SHIFT);
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. Every non-idle state lasts whole half-periods.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_ex) begin
                    if (w_need_gap) begin
                        w_state_nxt = S_GAP;
                    end else begin
                        w_state_nxt = S_SETUP;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_GAP;
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    w_state_nxt = S_XFER;
                end else begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_XFER: begin
                // Stay through the half-period that follows the final edge.
                if (w_tick && (r_edge_cnt == LAST_EDGE)) begin
                    w_state_nxt = S_END;
                end else begin
                    w_state_nxt = S_XFER;
                end
            end
            S_END: begin
                if (w_tick) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_END;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Half-period divider: loads on acceptance, then reloads at each boundary.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= {DIVW{1'b0}};
        end else if (w_accept) begin
            r_div <= i_clkdiv;
        end else if (r_state == S_IDLE) begin
            r_div <= r_div;
        end else if (w_tick) begin
            r_div <= r_clkdiv;
        end else begin
            r_div <= r_div - DIVW'(1);
        end
    end

    // Transfer datapath: request latching, sclk/mosi/cs_n and the shift registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clkdiv   <= {DIVW{1'b0}};
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_cs_sel   <= {CSW{1'b0}};
            r_hold     <= 1'b0;
            r_tx       <= {WIDTH{1'b0}};
            r_rx       <= {WIDTH{1'b0}};
            r_edge_cnt <= {ECW{1'b0}};
            r_cs_held  <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b1;
            r_cs_n     <= {NCS{1'b1}};
            r_wa       <= 1'b0;
        end else if (w_accept) begin
            r_clkdiv   <= i_clkdiv;
            r_cpol     <= i_cpol;
            r_cpha     <= i_cpha;
            r_cs_sel   <= i_cs_sel;
            r_hold     <= i_hold;
            r_tx       <= i_so;
            r_rx       <= {WIDTH{1'b0}};
            r_edge_cnt <= {ECW{1'b0}};
            r_wa       <= 1'b1;
            r_sclk     <= i_cpol;
            if (w_need_gap) begin
                r_cs_n    <= {NCS{1'b1}};
                r_cs_held <= 1'b0;
                r_mosi    <= 1'b1;
            end else begin
                r_cs_n    <= cs_pattern(i_cs_sel);
                r_mosi    <= i_so[WIDTH-1];
            end
        end else if (w_gap_done) begin
            r_cs_n <= cs_pattern(r_cs_sel);
            r_mosi <= r_tx[WIDTH-1];
        end else if (w_edge_fire) begin
            r_sclk     <= ~r_sclk;
            r_edge_cnt <= w_edge_num;
            // miso is captured on the same clk edge that creates the sampling sclk edge.
            if (w_sample) begin
                r_rx <= {r_rx[WIDTH-2:0], i_miso};
            end
            if (w_shift) begin
                r_mosi <= r_tx[WIDTH-2];
                r_tx   <= {r_tx[WIDTH-2:0], 1'b0};
            end
        end else if (w_done) begin
            r_wa   <= 1'b0;
            r_mosi <= 1'b1;
            r_sclk <= r_cpol;
            if (r_hold) begin
                r_cs_held <= 1'b1;
            end else begin
                r_cs_n    <= {NCS{1'b1}};
                r_cs_held <= 1'b0;
            end
        end
    end

    // Receive-valid flag and output word. A completion takes priority over ack.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rv <= 1'b0;
            r_si <= {WIDTH{1'b1}};
        end else if (w_done) begin
            r_rv <= 1'b1;
            r_si <= r_rx;
        end else if (w_accept) begin
            r_rv <= 1'b0;
            r_si <= {WIDTH{1'b1}};
        end else if (i_ack && r_rv) begin
            r_rv <= 1'b0;
            r_si <= {WIDTH{1'b1}};
        end
    end

    assign o_sclk = r_sclk;
    assign o_mosi = r_mosi;
    assign o_cs_n = r_cs_n;
    assign o_wa   = r_wa;
    assign o_rv   = r_rv;
    assign o_si   = r_si;

endmodule

// File: tb/tb_spi_master.sv
// ----------------------------------------------------------------------------
// tb_spi_master
//
// Directed bench for spi_master with WIDTH=8 and NCS=2. miso is either looped
// back from mosi or driven by a small slave model. The slave model counts sclk
// edges on its own and uses its own notion of cpha. It captures mosi on its
// sampling edges and shifts out a fixed pattern on the other edges.
// ----------------------------------------------------------------------------
module tb_spi_master;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_clkdiv;
    logic        i_cpol;
    logic        i_cpha;
    logic [0:0]  i_cs_sel;
    logic        i_hold;
    logic [7:0]  i_so;
    logic        i_ex;
    logic        i_ack;
    logic [7:0]  o_si;
    logic        o_rv;
    logic        o_wa;
    logic        o_sclk;
    logic        o_mosi;
    logic        i_miso;
    logic [1:0]  o_cs_n;

    // Slave model state.
    logic        use_loop;
    logic        slv_arm;
    logic        slv_cpha;
    logic [7:0]  slv_pat;
    logic [7:0]  slv_rx;
    logic        slv_miso;
    logic        slv_prev;
    int          slv_cnt;
    int          slv_idx;

    // Results of the most recent transfer.
    int          wa_cyc;
    int          c0_low;
    int          c1_low;
    int          gap_cyc;
    int          rises;
    logic        setup_sclk;
    logic        acc_rv;
    logic [7:0]  mosi_cap;

    int          n_pass = 0;
    int          n_total = 0;
    int          n_fail = 0;
    int          highs;
    logic [1:0]  md;

    always #5 clk = ~clk;

    assign i_miso = use_loop ? o_mosi : slv_miso;

    spi_master #(.WIDTH(8), .NCS(2), .DIVW(16)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_clkdiv (i_clkdiv),
        .i_cpol   (i_cpol),
        .i_cpha   (i_cpha),
        .i_cs_sel (i_cs_sel),
        .i_hold   (i_hold),
        .i_so     (i_so),
        .i_ex     (i_ex),
        .i_ack    (i_ack),
        .o_si     (o_si),
        .o_rv     (o_rv),
        .o_wa     (o_wa),
        .o_sclk   (o_sclk),
        .o_mosi   (o_mosi),
        .i_miso   (i_miso),
        .o_cs_n   (o_cs_n)
    );

    // Slave model: while disarmed it reloads. While armed it reacts to each sclk edge.
    always @(o_sclk or slv_arm or slv_pat) begin
        if (!slv_arm) begin
            slv_cnt  = 0;
            slv_idx  = 7;
            slv_miso = slv_pat[7];
            slv_rx   = 8'h00;
            slv_prev = o_sclk;
        end else if (o_sclk !== slv_prev) begin
            slv_prev = o_sclk;
            slv_cnt  = slv_cnt + 1;
            if ((slv_cnt % 2 == 1) != slv_cpha) begin
                slv_rx = {slv_rx[6:0], o_mosi};
            end else if (!(slv_cpha && slv_cnt == 1) && slv_idx > 0) begin
                slv_idx  = slv_idx - 1;
                slv_miso = slv_pat[slv_idx];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request and watches the bus until wa drops or a cycle budget runs out.
    task automatic xfer(input logic [7:0] so, input logic cpol, input logic cpha,
                        input logic sel, input logic hold, input logic [15:0] div,
                        input logic loop, input logic [7:0] pat, input int ack_at);
        logic prev;
        @(negedge clk);
        i_so = so; i_cpol = cpol; i_cpha = cpha; i_cs_sel = sel; i_hold = hold;
        i_clkdiv = div; use_loop = loop; slv_pat = pat; slv_cpha = cpha;
        i_ex = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ex = 1'b0;
        slv_arm = 1'b1;
        setup_sclk = o_sclk;
        acc_rv = o_rv;
        prev = o_sclk;
        wa_cyc = 0; c0_low = 0; c1_low = 0; gap_cyc = 0; rises = 0;
        while (o_wa === 1'b1 && wa_cyc < 2000) begin
            wa_cyc++;
            if (o_cs_n == 2'b11) gap_cyc++;
            if (!o_cs_n[0]) c0_low++;
            if (!o_cs_n[1]) c1_low++;
            if (prev == 1'b0 && o_sclk == 1'b1) rises++;
            prev = o_sclk;
            i_ack = (wa_cyc == ack_at);
            @(negedge clk);
        end
        i_ack = 1'b0;
        mosi_cap = slv_rx;
        slv_arm = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_clkdiv = 16'd0; i_cpol = 1'b0; i_cpha = 1'b0; i_cs_sel = 1'b0;
        i_hold = 1'b0; i_so = 8'h00; i_ex = 1'b0; i_ack = 1'b0;
        use_loop = 1'b1; slv_arm = 1'b0; slv_cpha = 1'b0; slv_pat = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_sclk", o_sclk, 1'b0);
        chk("rst_mosi", o_mosi, 1'b1);
        chk("rst_cs_n", o_cs_n, 2'b11);
        chk("rst_wa", o_wa, 1'b0);
        chk("rst_rv", o_rv, 1'b0);
        chk("rst_si", o_si, 8'hFF);
        i_rst = 1'b0;

        // Mode 0, H=1, loopback of 0xA5.
        xfer(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 8'h00, 0);
        chk("m0_wa", wa_cyc, 18);
        chk("m0_si", o_si, 8'hA5);
        chk("m0_rv", o_rv, 1'b1);
        chk("m0_rises", rises, 8);
        chk("m0_cs0_low", c0_low, 18);
        chk("m0_cs1_low", c1_low, 0);
        chk("m0_mosi_msb_first", mosi_cap, 8'hA5);

        // Modes 1..3, H=4, slave returns 0xC3.
        for (int m = 1; m <= 3; m++) begin
            md = m[1:0];
            xfer(8'h3C, md[1], md[0], 1'b0, 1'b0, 16'd3, 1'b0, 8'hC3, 0);
            chk($sformatf("m%0d_acc_rv", m), acc_rv, 1'b0);
            chk($sformatf("m%0d_setup_sclk", m), setup_sclk, md[1]);
            chk($sformatf("m%0d_wa", m), wa_cyc, 72);
            chk($sformatf("m%0d_si", m), o_si, 8'hC3);
            chk($sformatf("m%0d_mosi", m), mosi_cap, 8'h3C);
            chk($sformatf("m%0d_idle_sclk", m), o_sclk, md[1]);
        end

        // Two words on cs_sel=1: hold=1 then hold=0.
        xfer(8'h96, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b1, 8'h00, 0);
        chk("h1_si", o_si, 8'h96);
        chk("h1_cs1_low", c1_low, 18);
        chk("h1_cs_after", o_cs_n, 2'b01);
        highs = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_cs_n != 2'b01) highs++;
        end
        chk("h1_cs_idle_held", highs, 0);
        xfer(8'h69, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 8'h00, 0);
        chk("h2_si", o_si, 8'h69);
        chk("h2_wa_no_gap", wa_cyc, 18);
        chk("h2_cs1_low", c1_low, 18);
        chk("h2_cs0_low", c0_low, 0);
        chk("h2_cs_after", o_cs_n, 2'b11);

        // Hold cs 0 at H=2, then switch to cs 1 (GAP). ack lands on the completion cycle.
        xfer(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 8'h00, 0);
        chk("g0_wa", wa_cyc, 36);
        chk("g0_cs_after", o_cs_n, 2'b10);
        xfer(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 8'h00, 38);
        chk("g1_wa", wa_cyc, 38);
        chk("g1_gap", gap_cyc, 2);
        chk("g1_cs1_low", c1_low, 36);
        chk("g1_cs0_low", c0_low, 0);
        chk("ack_same_rv", o_rv, 1'b1);
        chk("ack_same_si", o_si, 8'h0F);
        i_ack = 1'b1;
        @(negedge clk);
        i_ack = 1'b0;
        chk("ack_late_rv", o_rv, 1'b0);
        chk("ack_late_si", o_si, 8'hFF);

        // Reset asserted in the middle of a mode-3 transfer, away from any clk edge.
        @(negedge clk);
        i_so = 8'h55; i_cpol = 1'b1; i_cpha = 1'b1; i_cs_sel = 1'b0; i_hold = 1'b0;
        i_clkdiv = 16'd3; use_loop = 1'b1; i_ex = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ex = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_cs_n", o_cs_n, 2'b10);
        chk("pre_rst_sclk", o_sclk, 1'b1);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_cs_n", o_cs_n, 2'b11);
        chk("arst_sclk", o_sclk, 1'b0);
        chk("arst_mosi", o_mosi, 1'b1);
        chk("arst_wa", o_wa, 1'b0);
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        xfer(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 8'h00, 0);
        chk("post_rst_wa", wa_cyc, 36);
        chk("post_rst_si", o_si, 8'h5A);
        chk("post_rst_rv", o_rv, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

Parametrised SPI master for the SoC peripheral bus, replacing the fixed 8-bit mode-3-only byte engine. It adds configurable word width, all four CPOL/CPHA modes, multiple chip selects with optional CS hold across words, and a receive-valid flag. It keeps the `ex`/`ack`/`wa` CPU-side handshake.

## Interface
- `WIDTH`, 8: bits per transfer word, ≥ 2.
- `NCS`, 2: number of chip-select outputs, ≥ 2.
- `DIVW`, 16: width of `clkdiv`.
- `clk` in 1: sole clock. All logic is rising-edge only.
- `rst` in 1: asynchronous, active-high reset.
- `clkdiv` in DIVW: half-period of `sclk` is `clkdiv+1` clk cycles (H).
- `cpol` in 1: SCLK idle level.
- `cpha` in 1: 0 = sample on leading edge; 1 = sample on trailing edge.
- `cs_sel` in $clog2(NCS): index of the target chip select.
- `hold` in 1: keep CS asserted after this word.
- `so` in WIDTH: word to send, MSB first.
- `ex` in 1: start-request pulse/level.
- `ack` in 1: clears `rv`.
- `si` out WIDTH: received word. Reads all ones while `rv`=0.
- `rv` out 1: received word valid.
- `wa` out 1: busy.
- `sclk`, `mosi` out 1; `miso` in 1.
- `cs_n` out NCS: active-low chip selects.

## Operation
- Reset values:
  - `sclk`=0, `mosi`=1, `cs_n`=all ones, `wa`=0, `rv`=0.
  - Receive register = 0, latched cpol/cpha/cs_sel/clkdiv = 0.
  - CS-held flag = 0.
- Reset mid-transfer aborts immediately and asynchronously to these values.
- FSM states: IDLE, SETUP, XFER, END, GAP.
- **IDLE**:
  - `sclk` = latched cpol, `mosi`=1.
  - `ex`=1 accepts a request and latches `so`, `cpol`, `cpha`, `cs_sel`, `hold` and `clkdiv`.
  - On acceptance, `rv` clears and `wa` asserts.
  - If CS is held on a different index than the new `cs_sel`, go to GAP; otherwise go to SETUP.
- **GAP** (1 H): all `cs_n` high, then SETUP.
- **SETUP** (1 H): selected `cs_n` low, `mosi` = MSB, `sclk` = cpol.
- **XFER** (2·WIDTH half-periods):
  - `sclk` toggles at the start of each half-period, giving 2·WIDTH edges. Odd edges are leading, even edges are trailing.
  - cpha=0: sample `miso` on each leading edge; shift the next bit onto `mosi` on trailing edges 2..2W−2.
  - cpha=1: drive the next bit on leading edges (the first leading edge keeps the MSB); sample on trailing edges.
  - The final edge returns `sclk` to cpol.
- **END** (1 H):
  - `sclk` = cpol.
  - At the end of END: `wa`→0, `rv`→1, `si` = received word. Selected `cs_n` goes high unless `hold`=1.
  - Return to IDLE.
- While `wa`=1, `ex` is ignored and input changes have no effect.
- `ack` with `rv`=1 clears `rv` next cycle.
- Simultaneous events:
  - `ack` in the same cycle as END completion: completion wins, `rv`=1.
  - `ack` and an accepted `ex` in the same cycle: `rv`=0.
- A held CS stays low indefinitely in IDLE. It is released only by a completed word with `hold`=0, a GAP, or reset.
- Divider: a down-counter reloads with the latched `clkdiv` at each half-period boundary. `clkdiv`=0 gives H=1 (sclk = clk/2). The counter wraps only by reload, never by underflow.

## Timing
- Acceptance: `ex` high in IDLE at edge t; `wa`=1 and FSM in SETUP from t+1.
- Busy duration: `wa` high for (2·WIDTH+2)·H cycles, plus H if GAP is taken.
- `rv` and `si` update on the same edge that `wa` falls.
- The next `ex` can be accepted that same cycle; an `ex` held high is accepted on the following edge.
- Output timing: `mosi` and `cs_n` change only on half-period boundaries. `miso` is registered at the clk edge that produces the sampling sclk edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Mode 0, WIDTH=8, clkdiv=0, `so`=0xA5, miso looped to mosi → `wa` high for 18 cycles, `si`=0xA5, `rv`=1. On the scope, MSB first, 8 rising edges, `cs_n[0]` low for 18 cycles.
- Modes 1–3 with clkdiv=3, `so`=0x3C, slave model returning 0xC3 → `si`=0xC3. Sampling edge and idle `sclk` level are correct for each mode, and `wa` stays high for 72 cycles.
- Two words with `hold`=1 then `hold`=0 on `cs_sel`=1 → `cs_n[1]` stays low between the words; `cs_n[0]` stays high throughout.
- Held CS on index 0, then `ex` with `cs_sel`=1 → GAP of H with both `cs_n` high, then `cs_n[1]` low. `wa` duration is 19·H.
- `ack` on the completion cycle → `rv` stays 1. `ack` one cycle later → `rv`=0 and `si`=all ones.
- Assert `rst` mid-XFER → immediately `cs_n`=all ones, `sclk`=0, `mosi`=1, `wa`=0. After deassertion, a new transfer completes normally.
